// File: rtl/stream_credit_pkg.sv
// Shared definitions for the credit-based stream transmitter.
package stream_credit_pkg;

  localparam int unsigned CREDITS_DEFAULT = 8;

  function automatic int unsigned credit_cnt_width(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Receiver-slot credit counter with saturation at the initial count and a
// sticky error flag on over-return. Reset clears the flag; init does not.
module credit_counter
  import stream_credit_pkg::*;
#(
  parameter int unsigned Credits = CREDITS_DEFAULT,
  parameter int unsigned CntW    = credit_cnt_width(Credits)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_i,
  input  logic            dec_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            nonzero_o,
  output logic            err_o
);

  localparam logic [CntW-1:0] Full = CntW'(Credits);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [CntW:0]   sum;
  logic            overflow;

  // One extra bit so Full+1 is distinguishable even when Credits = 2^CntW-1.
  always_comb begin
    sum      = {1'b0, cnt_q} - {{CntW{1'b0}}, dec_i} + {{CntW{1'b0}}, inc_i};
    overflow = (sum > {1'b0, Full});
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (init_i) begin
      cnt_d = Full;
    end else if (overflow) begin
      cnt_d = Full;
      err_d = 1'b1;
    end else begin
      cnt_d = sum[CntW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= Full;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign nonzero_o = (cnt_q != '0);
  assign err_o     = err_q;

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: valid/ready upstream, registered valid-only
// link. Define STREAM_CREDIT_TX_BYPASS_EN to let a same-cycle credit return
// raise enq_rdy_o at zero credits.
module stream_credit_tx
  import stream_credit_pkg::*;
#(
  parameter  int unsigned Credits   = CREDITS_DEFAULT,
  parameter  int unsigned WordWidth = 64,
  localparam int unsigned CntW      = credit_cnt_width(Credits)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_vld_i,
  input  logic [WordWidth-1:0] enq_payload_i,
  output logic                 enq_rdy_o,
  output logic                 tx_vld_o,
  output logic [WordWidth-1:0] tx_payload_o,
  input  logic                 credit_ret_i,
  input  logic                 flush_i,
  output logic [CntW-1:0]      credit_cnt_o,
  output logic                 credit_err_o
);

  logic fire;
  logic nonzero;

  credit_counter #(
    .Credits (Credits),
    .CntW    (CntW)
  ) u_credit_counter (
    .clk       (clk),
    .rst       (rst),
    .init_i    (flush_i),
    .dec_i     (fire),
    .inc_i     (credit_ret_i),
    .cnt_o     (credit_cnt_o),
    .nonzero_o (nonzero),
    .err_o     (credit_err_o)
  );

`ifdef STREAM_CREDIT_TX_BYPASS_EN
  assign enq_rdy_o = (nonzero | credit_ret_i) & ~flush_i;
`else
  assign enq_rdy_o = nonzero & ~flush_i;
`endif

  assign fire = enq_vld_i & enq_rdy_o;

  // enq_rdy_o already excludes flush, so fire alone decides tx_vld_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_vld_o     <= 1'b0;
      tx_payload_o <= '0;
    end else begin
      tx_vld_o <= fire;
      if (fire) begin
        tx_payload_o <= enq_payload_i;
      end
    end
  end

endmodule

// File: doc/stream_credit_tx.md
# stream_credit_tx

Credit-based stream transmitter: the sending end of a link whose receiving end is a valid/ready stream FIFO with no backpressure wire back to the sender. It accepts words on an upstream valid/ready port and forwards them on a registered, valid-only link. It tracks how many free receiver FIFO slots remain, so the receiver can never overflow. Receiver pops return credits one per cycle. Used between pipeline stages separated by long wires, where a combinational ready path is not acceptable.

## Interface
- `Credits`, default 8: receiver FIFO depth, i.e. the initial credit count; must be ≥1 and equal the receiver `Depth`.
- `WordWidth`, default 64: payload width.
- `clk` input 1: clock; all state on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `enq_vld_i` input 1: upstream word valid.
- `enq_payload_i` input WordWidth: upstream word.
- `enq_rdy_o` output 1: upstream ready.
- `tx_vld_o` output 1: link word valid, registered; no ready exists on the link.
- `tx_payload_o` output WordWidth: link word, registered.
- `credit_ret_i` input 1: one credit returned this cycle (receiver popped one word).
- `flush_i` input 1: link flush, asserted in the same cycle as the receiver FIFO flush.
- `credit_cnt_o` output CntW: current credit count, where CntW = $clog2(Credits+1).
- `credit_err_o` output 1: sticky flag set on a credit return that would overflow.

## Operation
- fire = enq_vld_i & enq_rdy_o.
- enq_rdy_o = (cnt != 0) & ~flush_i.
- Next credit count, evaluated in priority order:
  - rst: cnt = Credits.
  - flush_i: cnt = Credits. credit_ret_i in the flush cycle is ignored, because the receiver is flushed in the same cycle.
  - Otherwise cnt_next = cnt − fire + credit_ret_i, computed at CntW+1 bits.
  - fire and credit_ret_i in the same cycle: cnt unchanged.
- Overflow (credit_ret_i & ~fire at cnt == Credits):
  - cnt saturates at Credits.
  - credit_err_o is set and stays set until rst. flush_i does not clear it.
- Underflow cannot occur, because fire requires cnt != 0.
- Link register:
  - On fire: tx_vld_o = 1 and tx_payload_o = enq_payload_i in the next cycle.
  - Without fire: tx_vld_o = 0 in the next cycle; tx_payload_o holds its last value.
  - flush_i forces tx_vld_o = 0 in the next cycle.
- Words leave in acceptance order; nothing is dropped except under flush_i.
- enq_payload_i is a don't-care when enq_vld_i = 0.

## Timing
- Reset values: tx_vld_o = 0, tx_payload_o = 0, credit_cnt_o = Credits, credit_err_o = 0, enq_rdy_o = 1 (when Credits ≥ 1 and flush_i = 0).
- Latency from enq fire to tx_vld_o is 1 cycle. Throughput is 1 word/cycle while credits remain.
- A returned credit at cnt = 0 raises enq_rdy_o in the next cycle (no-bypass build).
- Round-trip: the link sustains full rate only if Credits ≥ link round-trip latency in cycles.
- rst mid-stream discards the in-flight tx register contents. The receiver must be reset in the same cycle.
- enq_rdy_o depends only on registers and flush_i, never on enq_vld_i.

## Configuration
- `STREAM_CREDIT_TX_BYPASS_EN`
  - Defined: enq_rdy_o = ((cnt != 0) | credit_ret_i) & ~flush_i, so a credit returned at cnt = 0 is spent in the same cycle and cnt stays 0.
  - Undefined: no combinational path from credit_ret_i to enq_rdy_o.
- All other behaviour is identical in both builds.

## Structure
- Package `stream_credit_pkg`:
  - function `credit_cnt_width(Credits)` returning $clog2(Credits+1);
  - localparam default for `Credits`.
- Sub-module `credit_counter`:
  - parameters Credits and CntW;
  - inputs clk, rst, init_i (flush), dec_i (fire), inc_i (credit return);
  - outputs cnt_o, nonzero_o, err_o.
  - Holds the saturation and sticky-error logic. The top level holds the link register and handshake.

## Test plan
- Reset: assert rst 2 cycles → credit_cnt_o = 8, tx_vld_o = 0, credit_err_o = 0, enq_rdy_o = 1.
- Burst with no returns: 10 words 0x0..0x9 offered back-to-back →
  - words 0x0..0x7 accepted;
  - enq_rdy_o = 0 after the 8th fire;
  - tx_payload_o shows 0x0..0x7 in order, each 1 cycle after its fire;
  - credit_cnt_o = 0.
- Credit return at empty: cnt = 0, pulse credit_ret_i with enq_vld_i held →
  - no-bypass: fire occurs in the next cycle and cnt stays 0;
  - bypass build: fire occurs in the same cycle.
- Simultaneous fire and return at cnt = 3 for 5 cycles → cnt stays 3 and 5 words are sent.
- Overflow: credit_ret_i at cnt = 8 → cnt stays 8, credit_err_o = 1. It persists through flush_i and clears only on rst.
- Flush mid-burst: flush_i with a word in the tx register and credit_ret_i = 1 →
  - tx_vld_o = 0 in the next cycle;
  - enq_rdy_o = 0 in the flush cycle;
  - credit_cnt_o = 8, with the return ignored.
